tx_top: RTL and testbench

TX_TOP -- requirements
Module: tx_top

---
 rtl/tx_pkg.sv | 15 +
 rtl/tx_fifo.sv | 69 ++++++
 rtl/tx_top.sv | 146 ++++++++++++++
 tb/tb_tx_top.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/tx_pkg.sv
// Shared definitions for the framing transmitter: FSM states, the start-of-frame
// marker and the default payload buffer depth.
package tx_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      HDR     = 2'd1,
      PAYLOAD = 2'd2,
      CSUM    = 2'd3
   } tx_state_t;

   localparam logic [7:0] SOF_BYTE           = 8'hA5;
   localparam int         DEFAULT_FIFO_DEPTH = 8;

endpackage

// File: rtl/tx_fifo.sv
// Payload byte buffer for tx_top. Read and write pointers wrap modulo DEPTH and a
// separate level counter provides full/empty. The head entry and the one behind it
// are both visible, so the framer can present the next payload byte on the same
// edge that pops the current one.
module tx_fifo
   import tx_pkg::*;
#(
   parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    push,
   input  logic [7:0]              wdata,
   input  logic                    pop,
   output logic [7:0]              rdata,
   output logic [7:0]              rdata_next,
   output logic [$clog2(DEPTH):0]  level,
   output logic                    full,
   output logic                    empty
);

   localparam int              AW       = $clog2(DEPTH);
   localparam int              LW       = AW + 1;
   localparam logic [AW:0]     LVL_FULL = DEPTH[AW:0];

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] rd_ptr_next;
   logic          wr_en;
   logic          rd_en;

   assign full        = (level == LVL_FULL);
   assign empty       = (level == '0);
   assign wr_en       = push && (!full || pop);
   assign rd_en       = pop && !empty;
   assign rd_ptr_next = rd_ptr + AW'(1);
   assign rdata       = mem[rd_ptr];
   assign rdata_next  = mem[rd_ptr_next];

   // Storage array: written on an accepted push, contents need no reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // Pointers and level: a simultaneous push and pop leaves the level unchanged.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (rd_en) begin
            rd_ptr <= rd_ptr_next;
         end
         if (wr_en && !rd_en) begin
            level <= level + LW'(1);
         end else if (rd_en && !wr_en) begin
            level <= level - LW'(1);
         end
      end
   end

endmodule

// File: rtl/tx_top.sv
// Framing transmitter: buffers upstream bytes and, once a full frame's worth is
// held, sends SOF 0xA5, FRAME_LEN payload bytes and an 8-bit additive checksum
// over a registered valid/ready stream.
module tx_top
   import tx_pkg::*;
#(
   parameter int FRAME_LEN  = 4,
   parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic [7:0] i_data,
   input  logic       i_vld,
   output logic       o_rdy,
   output logic [7:0] o_x,
   output logic       o_vld,
   input  logic       i_rdy
);

   localparam int            LW        = $clog2(FIFO_DEPTH) + 1;
   localparam logic [LW-1:0] FRAME_LVL = FRAME_LEN[LW-1:0];
   localparam logic [3:0]    LAST_IDX  = 4'(FRAME_LEN - 1);

   tx_state_t     state;
   tx_state_t     state_nxt;
   logic [7:0]    x_nxt;
   logic          vld_nxt;
   logic [3:0]    cnt;
   logic [3:0]    cnt_nxt;
   logic [7:0]    csum;
   logic [7:0]    csum_nxt;
   logic          push;
   logic          pop;
   logic          hs;
   logic          last_byte;
   logic          frame_ready;
   logic [7:0]    fifo_head;
   logic [7:0]    fifo_second;
   logic [LW-1:0] level;
   logic          fifo_full;
   logic          fifo_empty;

   assign o_rdy       = !fifo_full;
   assign push        = i_vld && o_rdy;
   assign hs          = o_vld && i_rdy;
   assign last_byte   = (cnt == LAST_IDX);
   assign frame_ready = !fifo_empty && (level >= FRAME_LVL);

   tx_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rstn       (rstn),
      .push       (push),
      .wdata      (i_data),
      .pop        (pop),
      .rdata      (fifo_head),
      .rdata_next (fifo_second),
      .level      (level),
      .full       (fifo_full),
      .empty      (fifo_empty)
   );

   // State register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state: a frame starts only with a whole frame buffered, and every later
   // step waits for the downstream handshake on the byte currently presented.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (frame_ready)      state_nxt = HDR;
         HDR:     if (hs)               state_nxt = PAYLOAD;
         PAYLOAD: if (hs && last_byte)  state_nxt = CSUM;
         CSUM:    if (hs)               state_nxt = IDLE;
         default:                       state_nxt = IDLE;
      endcase
   end

   // Output decode: compute the byte to present next; without a handshake the
   // current byte is held, and the payload pop happens on the payload handshake.
   always_comb begin
      x_nxt    = o_x;
      vld_nxt  = o_vld;
      cnt_nxt  = cnt;
      csum_nxt = csum;
      pop      = 1'b0;
      unique case (state)
         IDLE: begin
            vld_nxt  = 1'b0;
            x_nxt    = 8'h00;
            cnt_nxt  = '0;
            csum_nxt = 8'h00;
            if (frame_ready) begin
               vld_nxt = 1'b1;
               x_nxt   = SOF_BYTE;
            end
         end
         HDR: begin
            if (hs) begin
               x_nxt = fifo_head;
            end
         end
         PAYLOAD: begin
            if (hs) begin
               pop      = 1'b1;
               cnt_nxt  = cnt + 4'd1;
               csum_nxt = csum + o_x;
               x_nxt    = last_byte ? (csum + o_x) : fifo_second;
            end
         end
         CSUM: begin
            if (hs) begin
               vld_nxt = 1'b0;
               x_nxt   = 8'h00;
            end
         end
         default: begin
            vld_nxt = 1'b0;
            x_nxt   = 8'h00;
         end
      endcase
   end

   // Registered stream outputs plus payload counter and checksum accumulator.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         o_x   <= 8'h00;
         o_vld <= 1'b0;
         cnt   <= '0;
         csum  <= 8'h00;
      end else begin
         o_x   <= x_nxt;
         o_vld <= vld_nxt;
         cnt   <= cnt_nxt;
         csum  <= csum_nxt;
      end
   end

endmodule

// File: tb/tb_tx_top.sv
// Directed bench for tx_top: a table of per-cycle {inputs, expected outputs}
// records plus a hand-written mid-frame reset sequence.
module tb_tx_top;

   typedef struct {
      logic       vld;
      logic [7:0] data;
      logic       rdy;
      logic [7:0] exp_x;
      logic       exp_vld;
      logic       exp_rdy;
   } vec_t;

   logic       clk;
   logic       rstn;
   logic [7:0] i_data;
   logic       i_vld;
   logic       o_rdy;
   logic [7:0] o_x;
   logic       o_vld;
   logic       i_rdy;

   vec_t vecs[$];
   int   vectors_applied = 0;
   int   miscompares     = 0;
   int   part_b_start;

   tx_top #(
      .FRAME_LEN  (4),
      .FIFO_DEPTH (8)
   ) dut (
      .clk    (clk),
      .rstn   (rstn),
      .i_data (i_data),
      .i_vld  (i_vld),
      .o_rdy  (o_rdy),
      .o_x    (o_x),
      .o_vld  (o_vld),
      .i_rdy  (i_rdy)
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   task automatic addVec(input logic v, input logic [7:0] d, input logic r,
                         input logic [7:0] ex, input logic ev, input logic er);
      vec_t t;
      t.vld = v; t.data = d; t.rdy = r;
      t.exp_x = ex; t.exp_vld = ev; t.exp_rdy = er;
      vecs.push_back(t);
   endtask

   task automatic checkOutput(input string name, input logic [7:0] ex,
                              input logic ev, input logic er);
      vectors_applied++;
      if (o_x !== ex || o_vld !== ev || o_rdy !== er) begin
         miscompares++;
         $display("[TB] FAIL %s: got x=%02h vld=%0b rdy=%0b, want x=%02h vld=%0b rdy=%0b",
                  name, o_x, o_vld, o_rdy, ex, ev, er);
      end
   endtask

   // Check the outputs left by earlier edges, then drive this record's inputs.
   task automatic applyStimulus(input int idx);
      @(negedge clk);
      checkOutput($sformatf("vec%0d", idx), vecs[idx].exp_x, vecs[idx].exp_vld,
                  vecs[idx].exp_rdy);
      i_vld  = vecs[idx].vld;
      i_data = vecs[idx].data;
      i_rdy  = vecs[idx].rdy;
   endtask

   task automatic pushIdle(input logic [7:0] d, input logic r);
      addVec(1'b1, d, r, 8'h00, 1'b0, 1'b1);
   endtask

   task automatic expectByte(input logic [7:0] ex, input logic r);
      addVec(1'b0, 8'h00, r, ex, 1'b1, 1'b1);
   endtask

   task automatic expectIdle();
      addVec(1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b1);
   endtask

   // Reset mid-frame while the 2nd payload byte is on the output.
   task automatic resetMidFrame();
      logic [7:0] bytes [4];
      bit found;
      bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         i_vld = 1'b1; i_data = bytes[k]; i_rdy = 1'b1;
      end
      @(negedge clk);
      i_vld = 1'b0; i_data = 8'h00;
      found = 1'b0;
      for (int n = 0; n < 20 && !found; n++) begin
         @(negedge clk);
         if (o_vld === 1'b1 && o_x === 8'h22) found = 1'b1;
      end
      vectors_applied++;
      if (!found) begin
         miscompares++;
         $display("[TB] FAIL wait_payload2: got no x=22 vld=1 within 20 cycles, want x=22 vld=1");
      end
      #2 rstn = 1'b0;
      #1 checkOutput("reset_async", 8'h00, 1'b0, 1'b1);
      @(negedge clk);
      rstn = 1'b1;
      #1 checkOutput("rdy_after_release", 8'h00, 1'b0, 1'b1);
      for (int n = 0; n < 6; n++) begin
         @(negedge clk);
         checkOutput($sformatf("no_csum%0d", n), 8'h00, 1'b0, 1'b1);
      end
   endtask

   initial begin
      clk    = 1'b0;
      rstn   = 1'b0;
      i_vld  = 1'b0;
      i_data = 8'h00;
      i_rdy  = 1'b0;

      // Basic frame 00..03, checksum 06.
      for (int b = 0; b < 4; b++) pushIdle(8'(b), 1'b1);
      addVec(1'b0, 8'hEE, 1'b1, 8'h00, 1'b0, 1'b1);
      expectByte(8'hA5, 1'b1);
      expectByte(8'h00, 1'b1);
      expectByte(8'h01, 1'b1);
      expectByte(8'h02, 1'b1);
      expectByte(8'h03, 1'b1);
      expectByte(8'h06, 1'b1);
      expectIdle();
      // All-FF payload, checksum wraps to FC.
      for (int b = 0; b < 4; b++) pushIdle(8'hFF, 1'b1);
      expectIdle();
      expectByte(8'hA5, 1'b1);
      for (int b = 0; b < 4; b++) expectByte(8'hFF, 1'b1);
      expectByte(8'hFC, 1'b1);
      expectIdle();
      // Backpressure for 3 cycles on payload byte 01.
      for (int b = 0; b < 4; b++) pushIdle(8'(b), 1'b1);
      expectIdle();
      expectByte(8'hA5, 1'b1);
      expectByte(8'h00, 1'b1);
      expectByte(8'h01, 1'b0);
      expectByte(8'h01, 1'b0);
      expectByte(8'h01, 1'b0);
      expectByte(8'h01, 1'b1);
      expectByte(8'h02, 1'b1);
      expectByte(8'h03, 1'b1);
      expectByte(8'h06, 1'b1);
      expectIdle();
      // Three bytes never start a frame; the fourth does.
      pushIdle(8'h10, 1'b1);
      pushIdle(8'h20, 1'b1);
      pushIdle(8'h30, 1'b1);
      for (int b = 0; b < 3; b++) addVec(1'b0, 8'h5A, 1'b1, 8'h00, 1'b0, 1'b1);
      pushIdle(8'h40, 1'b1);
      expectIdle();
      expectByte(8'hA5, 1'b1);
      expectByte(8'h10, 1'b1);
      expectByte(8'h20, 1'b1);
      expectByte(8'h30, 1'b1);
      expectByte(8'h40, 1'b1);
      expectByte(8'hA0, 1'b1);
      expectIdle();
      // Nine pushes with downstream stalled: eighth fills, ninth is refused.
      for (int b = 1; b <= 5; b++) addVec(1'b1, 8'(b), 1'b0, 8'h00, 1'b0, 1'b1);
      for (int b = 6; b <= 8; b++) addVec(1'b1, 8'(b), 1'b0, 8'hA5, 1'b1, 1'b1);
      addVec(1'b1, 8'h09, 1'b0, 8'hA5, 1'b1, 1'b0);
      addVec(1'b0, 8'h00, 1'b1, 8'hA5, 1'b1, 1'b0);
      addVec(1'b0, 8'h00, 1'b1, 8'h01, 1'b1, 1'b0);
      expectByte(8'h02, 1'b1);
      expectByte(8'h03, 1'b1);
      expectByte(8'h04, 1'b1);
      expectByte(8'h0A, 1'b1);
      expectIdle();
      expectByte(8'hA5, 1'b1);
      expectByte(8'h05, 1'b1);
      expectByte(8'h06, 1'b1);
      expectByte(8'h07, 1'b1);
      expectByte(8'h08, 1'b1);
      expectByte(8'h1A, 1'b1);
      expectIdle();
      expectIdle();
      part_b_start = vecs.size();
      // After the mid-frame reset: fresh frame needs four new pushes.
      pushIdle(8'h55, 1'b1);
      pushIdle(8'h66, 1'b1);
      pushIdle(8'h77, 1'b1);
      expectIdle();
      expectIdle();
      pushIdle(8'h88, 1'b1);
      expectIdle();
      expectByte(8'hA5, 1'b1);
      expectByte(8'h55, 1'b1);
      expectByte(8'h66, 1'b1);
      expectByte(8'h77, 1'b1);
      expectByte(8'h88, 1'b1);
      expectByte(8'hBA, 1'b1);
      expectIdle();

      repeat (2) @(negedge clk);
      checkOutput("in_reset", 8'h00, 1'b0, 1'b1);
      rstn = 1'b1;

      for (int i = 0; i < part_b_start; i++) applyStimulus(i);
      resetMidFrame();
      for (int i = part_b_start; i < vecs.size(); i++) applyStimulus(i);

      $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
      $finish;
   end

endmodule
